// File: rtl/fpu_issue.sv
// ---------------------------------------------------------------------------
// fpu_issue : single-outstanding issue/writeback controller in front of fpu
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_issue #(
  parameter logic [3:0] IDLE_OP = 4'b1111,
  parameter int         TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src0,
  input  logic [31:0] req_src1,
  input  logic [4:0]  req_rd,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_src0,
  output logic [31:0] fpu_src1,
  input  logic [31:0] fpu_result,
  input  logic        fpu_fin,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_to_int,
  output logic        wb_illegal,
  output logic        wb_timeout,
  output logic        busy
);

  localparam int         CW          = $clog2(TIMEOUT + 1);
  localparam logic [3:0] C_FIRST_ILL = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   src0_q, src0_d;
  logic [31:0]   src1_q, src1_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= IDLE_OP;
      src0_q    <= 32'd0;
      src1_q    <= 32'd0;
      rd_q      <= 5'd0;
      cnt_q     <= '0;
      data_q    <= 32'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src0_q    <= src0_d;
      src1_q    <= src1_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src0_d    = src0_q;
    src1_d    = src1_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    req_ready = 1'b0;
    fpu_op    = IDLE_OP;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_BUSY: begin
        fpu_op = op_q;
        cnt_d  = cnt_q + CW'(1);
        if (fpu_fin) begin
          data_d  = fpu_result;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          data_d    = 32'd0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        req_ready = wb_ready;
        if (wb_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new request overrides whatever the state logic above decided.
    if (req_valid && req_ready) begin
      op_d      = req_op;
      src0_d    = req_src0;
      src1_d    = req_src1;
      rd_d      = req_rd;
      cnt_d     = '0;
      timeout_d = 1'b0;
      if (req_op >= C_FIRST_ILL) begin
        illegal_d = 1'b1;
        data_d    = 32'd0;
        state_d   = S_DONE;
      end else begin
        illegal_d = 1'b0;
        state_d   = S_BUSY;
      end
    end
  end

  assign fpu_src0   = src0_q;
  assign fpu_src1   = src1_q;
  assign wb_valid   = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign wb_data    = data_q;
  assign wb_rd      = rd_q;
  assign wb_to_int  = (op_q >= 4'd8) && (op_q <= 4'd11);
  assign wb_illegal = illegal_q;
  assign wb_timeout = timeout_q;

endmodule

`default_nettype wire
